cnv_mc_port_rsp: RTL and testbench

Single-port Convey memory-controller responder: the MC side of one `mc_req_*` / `mc_rsp_*` port pair driven by the address generation units. It accepts load and store requests, asserts request stall on queue back-pressure, and applies a fixed minimum latency. Loads return data and read control; stores commit to a local backing array. It also handles flush/flush-complete. It is used in the stream microbench bench and in standalone FPGA loopback builds in place of the real MC port.

---
 rtl/cnv_mc_pkg.sv | 28 ++
 rtl/cnv_mc_req_fifo.sv | 44 ++++
 rtl/cnv_mc_port_rsp.sv | 129 ++++++++++++
 tb/tb_cnv_mc_port_rsp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnv_mc_pkg.sv
// Shared types for the Convey MC port responder: request record, widths, flush states.
package cnv_mc_pkg;

  localparam int MC_VADR_W  = 48;
  localparam int MC_DATA_W  = 64;
  localparam int MC_RDCTL_W = 32;
  localparam logic [1:0] MC_SIZE_QW = 2'd3;

  typedef enum logic {
    REQ_LD = 1'b0,
    REQ_ST = 1'b1
  } req_type_e;

  // wadr is the 64-bit word address (vadr[47:3]); requests are quadword aligned.
  typedef struct packed {
    req_type_e               typ;
    logic [MC_VADR_W-4:0]    wadr;
    logic [MC_DATA_W-1:0]    payload;
    logic [15:0]             stamp;
  } mc_req_t;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_PEND = 2'd1,
    FL_DONE = 2'd2
  } flush_state_e;

endpackage

// File: rtl/cnv_mc_req_fifo.sv
// In-order request queue, DEPTH entries (power of two); head is combinational from storage.
module cnv_mc_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cnv_mc_port_rsp.sv
// MC-side responder for one mc_req/mc_rsp port: in-order queue, fixed minimum latency, flush handshake.
// Build option CNV_MC_RSP_ADDR_DATA_EN: no backing array, load data echoes the request address.
module cnv_mc_port_rsp
  import cnv_mc_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int LAT          = 8,
  parameter int MEM_AW       = 10,
  parameter int STALL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mc_req_ld,
  input  logic                   mc_req_st,
  input  logic [MC_VADR_W-1:0]   mc_req_vadr,
  input  logic [1:0]             mc_req_size,
  input  logic [MC_DATA_W-1:0]   mc_req_wrd_rdctl,
  input  logic                   mc_req_flush,
  input  logic                   mc_rsp_stall,
  output logic                   mc_rd_rq_stall,
  output logic                   mc_wr_rq_stall,
  output logic                   mc_rsp_push,
  output logic [MC_DATA_W-1:0]   mc_rsp_data,
  output logic [MC_RDCTL_W-1:0]  mc_rsp_rdctl,
  output logic                   mc_rsp_flush_cmplt,
  output logic [31:0]            rd_cnt,
  output logic [31:0]            wr_cnt,
  output logic                   err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - STALL_MARGIN);

  logic [15:0]          now;
  logic [15:0]          age;
  mc_req_t              req;
  mc_req_t              head;
  logic                 full, empty;
  logic [CW-1:0]        count, cnt_nxt;
  logic                 accept, bad, due, ld_issue, st_issue, pop, stall_q;
  logic [MC_DATA_W-1:0] rd_data;
  flush_state_e         state, state_nxt;

  assign accept = (mc_req_ld ^ mc_req_st) & ~full;
  assign bad    = (mc_req_ld & mc_req_st)
                | ((mc_req_ld ^ mc_req_st) & (full | (mc_req_size != MC_SIZE_QW)));

  assign req = '{typ:     (mc_req_st ? REQ_ST : REQ_LD),
                 wadr:    mc_req_vadr[MC_VADR_W-1:3],
                 payload: mc_req_wrd_rdctl,
                 stamp:   now};

  cnv_mc_req_fifo #(.W($bits(mc_req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Stamp age is modular so the free-running counter may wrap underneath a queued request.
  assign age      = now - head.stamp;
  assign due      = ~reset & ~empty & (age >= 16'(LAT));
  assign ld_issue = due & (head.typ == REQ_LD) & ~mc_rsp_stall;
  assign st_issue = due & (head.typ == REQ_ST);
  assign pop      = ld_issue | st_issue;
  assign cnt_nxt  = count + CW'(accept) - CW'(pop);

`ifdef CNV_MC_RSP_ADDR_DATA_EN
  logic unused;
  assign rd_data = {16'd0, head.wadr, 3'b000};
  assign unused  = ^{mc_req_vadr[2:0], head.payload[MC_DATA_W-1:MC_RDCTL_W]};
`else
  logic [MC_DATA_W-1:0] mem [2**MEM_AW];
  logic unused;
  always_ff @(posedge clk) begin
    if (st_issue) mem[head.wadr[MEM_AW-1:0]] <= head.payload;
  end
  assign rd_data = mem[head.wadr[MEM_AW-1:0]];
  assign unused  = ^{mc_req_vadr[2:0], head.wadr[MC_VADR_W-4:MEM_AW]};
`endif

  assign mc_rsp_push    = ld_issue;
  assign mc_rsp_data    = ld_issue ? rd_data : '0;
  assign mc_rsp_rdctl   = ld_issue ? head.payload[MC_RDCTL_W-1:0] : '0;
  assign mc_rd_rq_stall = stall_q;
  assign mc_wr_rq_stall = stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      now     <= '0;
      err     <= 1'b0;
      stall_q <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      now     <= now + 16'd1;
      if (bad) err <= 1'b1;
      stall_q <= (cnt_nxt >= STALL_TH);
      rd_cnt  <= rd_cnt + 32'(ld_issue);
      wr_cnt  <= wr_cnt + 32'(st_issue);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FL_IDLE;
    else       state <= state_nxt;
  end

  // Completion waits on the post-update occupancy, so a same-cycle request is drained first.
  always_comb begin
    state_nxt          = state;
    mc_rsp_flush_cmplt = 1'b0;
    case (state)
      FL_IDLE: if (mc_req_flush) state_nxt = FL_PEND;
      FL_PEND: if (cnt_nxt == '0) state_nxt = FL_DONE;
      FL_DONE: begin
        mc_rsp_flush_cmplt = 1'b1;
        state_nxt          = mc_req_flush ? FL_PEND : FL_IDLE;
      end
      default: state_nxt = FL_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnv_mc_port_rsp.sv
// Bench for cnv_mc_port_rsp: directed scenarios plus random traffic against a queue-level reference model.
module tb_cnv_mc_port_rsp;

  localparam int DEPTH  = 16;
  localparam int LAT    = 8;
  localparam int MEM_AW = 10;
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld = 1'b0, st = 1'b0, flush = 1'b0, rsp_stall = 1'b0;
  logic [47:0] vadr = '0;
  logic [1:0]  size = 2'd3;
  logic [63:0] wrd = '0;

  logic        rd_stall, wr_stall, push, cmplt, err;
  logic [63:0] data;
  logic [31:0] rdctl, rd_cnt, wr_cnt;

  always #5 clk = ~clk;

  cnv_mc_port_rsp #(.DEPTH(DEPTH), .LAT(LAT), .MEM_AW(MEM_AW), .STALL_MARGIN(MARGIN)) dut (
    .clk                (clk),
    .reset              (reset),
    .mc_req_ld          (ld),
    .mc_req_st          (st),
    .mc_req_vadr        (vadr),
    .mc_req_size        (size),
    .mc_req_wrd_rdctl   (wrd),
    .mc_req_flush       (flush),
    .mc_rsp_stall       (rsp_stall),
    .mc_rd_rq_stall     (rd_stall),
    .mc_wr_rq_stall     (wr_stall),
    .mc_rsp_push        (push),
    .mc_rsp_data        (data),
    .mc_rsp_rdctl       (rdctl),
    .mc_rsp_flush_cmplt (cmplt),
    .rd_cnt             (rd_cnt),
    .wr_cnt             (wr_cnt),
    .err                (err)
  );

  // Reference model: requests held as a list with their accept cycle; a load's data is
  // resolved at accept time because the port is strictly in order.
  typedef struct { int t; bit is_st; logic [63:0] data; logic [31:0] rdctl; } mreq_t;
  typedef struct { logic [63:0] data; logic [31:0] rdctl; int cyc; } mrsp_t;

  mreq_t       mq[$];
  mrsp_t       exp_q[$];
  logic [63:0] mmem [int];
  mreq_t       r;
  mrsp_t       e;
  int          occ0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          flush_active = 0;
  bit          pend_err = 0, pend_stall = 0, pend_cmplt = 0;
  bit          vis_err = 0, vis_stall = 0, vis_cmplt = 0;
  logic [31:0] pend_rd = '0, pend_wr = '0, vis_rd = '0, vis_wr = '0;
  int          n_chk = 0, n_pass = 0;
  int          widx [16];

  always @(negedge clk) begin
    cyc++;
    vis_err = pend_err; vis_stall = pend_stall; vis_cmplt = pend_cmplt;
    vis_rd = pend_rd; vis_wr = pend_wr;
    pend_cmplt = 0;
    if (reset) begin
      mq.delete(); exp_q.delete();
      pend_err = 0; pend_stall = 0; pend_rd = '0; pend_wr = '0; flush_active = 0;
    end else begin
      occ0 = mq.size();
      if (occ0 > 0 && (cyc - mq[0].t) >= LAT && (mq[0].is_st || !rsp_stall)) begin
        r = mq.pop_front();
        if (r.is_st) pend_wr++;
        else begin
          exp_q.push_back('{data: r.data, rdctl: r.rdctl, cyc: cyc});
          pend_rd++;
        end
      end
      if (ld && st) pend_err = 1;
      else if (ld || st) begin
        if (size != 2'd3) pend_err = 1;
        if (occ0 == DEPTH) pend_err = 1;
        else begin
          r.t = cyc; r.is_st = st; r.rdctl = wrd[31:0];
`ifdef CNV_MC_RSP_ADDR_DATA_EN
          r.data = {16'd0, vadr};
`else
          if (st) begin
            mmem[int'(vadr[MEM_AW+2:3])] = wrd;
            r.data = wrd;
          end else
            r.data = mmem.exists(int'(vadr[MEM_AW+2:3])) ? mmem[int'(vadr[MEM_AW+2:3])] : 64'hx;
`endif
          mq.push_back(r);
        end
      end
      pend_stall = (mq.size() >= DEPTH - MARGIN);
      if (flush_active) begin
        if (mq.size() == 0) begin pend_cmplt = 1; flush_active = 0; end
      end else if (flush) flush_active = 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
  endtask

  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      chk("rd_rq_stall", 64'(rd_stall), 64'(vis_stall));
      chk("wr_rq_stall", 64'(wr_stall), 64'(vis_stall));
      chk("err", 64'(err), 64'(vis_err));
      chk("rd_cnt", 64'(rd_cnt), 64'(vis_rd));
      chk("wr_cnt", 64'(wr_cnt), 64'(vis_wr));
      chk("flush_cmplt", 64'(cmplt), 64'(vis_cmplt));
      if (push) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_push at cycle %0d: got push data %0h, expected no push", cyc, data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", data, e.data);
          chk("rsp_rdctl", 64'(rdctl), 64'(e.rdctl));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_chk++;
        e = exp_q.pop_front();
        $display("FAIL missing_push at cycle %0d: got none, expected data %0h due cycle %0d", cyc, e.data, e.cyc);
      end
    end
  end

  task automatic drive(input logic l, input logic s, input logic [47:0] a, input logic [63:0] d,
                       input logic [1:0] sz, input logic f, input logic rs);
    ld = l; st = s; vadr = a; wrd = d; size = sz; flush = f; rsp_stall = rs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rs);
    repeat (n) drive(1'b0, 1'b0, '0, '0, 2'd3, 1'b0, rs);
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() != 0 || exp_q.size() != 0) && n < 2000) begin idle(1, 1'b0); n++; end
    if (n >= 2000) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d requests outstanding, expected 0", mq.size());
    end
    idle(3, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(2, 1'b0); reset = 1'b0;
  endtask

  function automatic logic [47:0] mk_vadr(input int w);
    logic [63:0] rnd = {$urandom(), $urandom()};
    logic [47:0] v;
    v = rnd[47:0];
    v[MEM_AW+2:3] = w[MEM_AW-1:0];
    v[2:0] = 3'b000;
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) widx[k] = (k * 67 + 5) % (1 << MEM_AW);
    idle(3, 1'b0);
    reset = 1'b0;
    mon_en = 1;
    idle(2, 1'b0);

    // Store then load at 0x40, quiet port.
    drive(1'b0, 1'b1, 48'h40, 64'hA5A5, 2'd3, 1'b0, 1'b0);
    drain();
    drive(1'b1, 1'b0, 48'h40, 64'h7, 2'd3, 1'b0, 1'b0);
    drain();

    // Address-pattern load, preceded by a store to the same word.
    drive(1'b0, 1'b1, 48'h1234_5678_9A80, 64'hDEAD_BEEF_0123_4567, 2'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 48'h1234_5678_9A80, 64'h55, 2'd3, 1'b0, 1'b0);
    drain();

    // Seed the word pool so later random loads read defined data.
    for (int k = 0; k < 16; k++)
      drive(1'b0, 1'b1, mk_vadr(widx[k]), {$urandom(), $urandom()}, 2'd3, 1'b0, 1'b0);
    drain();

    // 17 loads against a stalled consumer: stall rises after the 12th, 17th is dropped.
    do_reset();
    for (int k = 0; k < 17; k++)
      drive(1'b1, 1'b0, mk_vadr(widx[k % 16]), 64'(k + 100), 2'd3, 1'b0, 1'b1);
    idle(5, 1'b1);
    drain();

    // Flush with three loads outstanding; a second flush merges while pending.
    do_reset();
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b0, mk_vadr(widx[k]), 64'(k + 200), 2'd3, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 2'd3, 1'b1, 1'b0);
    idle(2, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 2'd3, 1'b1, 1'b0);
    drain();

    // Flush with an empty queue and a same-cycle request.
    drive(1'b1, 1'b0, mk_vadr(widx[4]), 64'h33, 2'd3, 1'b1, 1'b0);
    drain();

    // Load and store together: dropped, error raised.
    do_reset();
    drive(1'b1, 1'b1, mk_vadr(widx[5]), 64'h99, 2'd3, 1'b0, 1'b0);
    drain();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int      rsel = $urandom_range(0, 99);
      logic [1:0] sz = ($urandom_range(0, 99) < 3) ? 2'd2 : 2'd3;
      logic    f  = ($urandom_range(0, 99) < 3);
      logic    rs = ($urandom_range(0, 99) < 25);
      logic [47:0] a = mk_vadr(widx[$urandom_range(0, 15)]);
      logic [63:0] d = {$urandom(), $urandom()};
      if (rsel < 35)      drive(1'b1, 1'b0, a, d, sz, f, rs);
      else if (rsel < 55) drive(1'b0, 1'b1, a, d, sz, f, rs);
      else if (rsel < 57) drive(1'b1, 1'b1, a, d, sz, f, rs);
      else                drive(1'b0, 1'b0, a, d, sz, f, rs);
    end
    drain();

    // Reset in the middle of outstanding loads: nothing may come out afterwards.
    do_reset();
    for (int k = 0; k < 5; k++)
      drive(1'b1, 1'b0, mk_vadr(widx[k]), 64'(k + 300), 2'd3, (k == 2), 1'b0);
    reset = 1'b1;
    idle(1, 1'b0);
    reset = 1'b0;
    idle(25, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
